// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, 8 data bits LSB first, even parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to extend the stop phase to two bit times.
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  if (DATA_BITS != 8) begin : g_bad_data_bits
    $error("uart_tx_framer: DATA_BITS must be 8");
  end
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("uart_tx_framer: CLKS_PER_BIT must be in 2..65535");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             txd_q, txd_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_MAX);

  // txd_d is the line level for the *next* cycle, so txd_q only moves on bit boundaries.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    txd_d     = txd_q;
    done_d    = 1'b0;

    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (tx_valid) begin
          state_d   = START;
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          shift_d   = tx_data;
          par_d     = ^tx_data;
          txd_d     = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d   = PARITY;
            bit_idx_d = 3'd0;
            txd_d     = par_q;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
          // bit_idx is free during STOP; reuse it to count the two stop bits.
          if (bit_idx_q == 3'd0) begin
            bit_idx_d = 3'd1;
          end else begin
            state_d   = IDLE;
            bit_idx_d = 3'd0;
            done_d    = 1'b1;
          end
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = ~tx_ready;
  assign txd      = txd_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer at CLKS_PER_BIT=4; outputs sampled on the falling edge.
module tb_uart_tx_framer;

  localparam int C = 4;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic       clk, rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, txd, tx_busy, tx_done;
  int         n_vec = 0;
  int         n_err = 0;

  uart_tx_framer #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a byte on a falling edge; it is accepted on the following rising edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
  endtask

  // exp[i] is the i-th line bit (start=bit0 ... stop=bit10). Walks the whole frame
  // cycle by cycle, then checks the tx_done cycle.
  task automatic check_frame(input string tag, input logic [10:0] exp, input bit keep_valid,
                             input logic [7:0] nxt, input int poke_at);
    int nbits;
    nbits = 10 + NSTOP;
    for (int k = 0; k < nbits * C; k++) begin
      int b;
      @(negedge clk);
      b = (k / C > 10) ? 10 : k / C;
      chk($sformatf("%s_txd_c%0d", tag, k), txd, exp[b]);
      chk($sformatf("%s_rdy_c%0d", tag, k), tx_ready, 1'b0);
      chk($sformatf("%s_busy_c%0d", tag, k), tx_busy, 1'b1);
      chk($sformatf("%s_done_c%0d", tag, k), tx_done, 1'b0);
      if (k == 0) begin
        if (keep_valid) tx_data = nxt;
        else begin
          tx_valid = 1'b0;
          tx_data  = ~tx_data;
        end
      end
      if (k == poke_at) begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
      end
      if (poke_at >= 0 && k == poke_at + 1) tx_valid = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, tx_done, 1'b1);
    chk({tag, "_done_rdy"}, tx_ready, 1'b1);
    chk({tag, "_done_txd"}, txd, 1'b1);
    if (!keep_valid) begin
      @(negedge clk);
      chk({tag, "_done_clr"}, tx_done, 1'b0);
      chk({tag, "_idle_txd"}, txd, 1'b1);
    end
  endtask

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    #3;
    chk("rst_txd", txd, 1'b1);
    chk("rst_rdy", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // A5: data 1,0,1,0,0,1,0,1 LSB first, parity 0
    send(8'hA5);
    check_frame("a5", 11'b10101001010, 1'b0, 8'h00, -1);

    // 01: parity 1
    send(8'h01);
    check_frame("x01", 11'b11000000010, 1'b0, 8'h00, -1);

    // Back-to-back 3C then FF: second start follows the done cycle directly
    send(8'h3C);
    check_frame("b2b_3c", 11'b10001111000, 1'b1, 8'hFF, -1);
    check_frame("b2b_ff", 11'b10111111110, 1'b0, 8'h00, -1);

    // 55 pulsed mid-frame must be ignored
    send(8'h01);
    check_frame("busy", 11'b11000000010, 1'b0, 8'h00, 20);
    for (int k = 0; k < 3 * C; k++) begin
      @(negedge clk);
      chk($sformatf("noextra_txd_c%0d", k), txd, 1'b1);
      chk($sformatf("noextra_rdy_c%0d", k), tx_ready, 1'b1);
    end

    // Reset during DATA bit 3 (frame cycles 16..19)
    send(8'hA5);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("prerst_txd", txd, 1'b0);
    chk("prerst_busy", tx_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_txd", txd, 1'b1);
    chk("midrst_busy", tx_busy, 1'b0);
    chk("midrst_rdy", tx_ready, 1'b1);
    chk("midrst_done", tx_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("postrst_done_c%0d", k), tx_done, 1'b0);
      chk($sformatf("postrst_txd_c%0d", k), txd, 1'b1);
    end
    send(8'hA5);
    check_frame("a5_again", 11'b10101001010, 1'b0, 8'h00, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
